fuzzy_pwm_driver: RTL

Downstream stage of the fuzzy membership/inference block: consumes its 12-bit pulse-width command PW and drives a single PWM output. The command passes through a one-entry pending register with a valid/ready handshake and is adopted only at period boundaries. The applied duty is slew-limited, so that start-up and shutdown ramp softly. A small state machine sequences enable and disable, and status outputs report period starts, the applied duty and ramp activity.

---
 rtl/fuzzy_pwm_driver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fuzzy_pwm_driver.sv
// Slew-limited PWM driver fed by the fuzzy inference stage: one-entry command
// buffer, period-boundary duty adoption, and an enable/disable sequencer.
module fuzzy_pwm_driver #(
    parameter int PERIOD    = 4095,
    parameter int SLEW_STEP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] pw_in,
    input  logic        pw_valid,
    output logic        pw_ready,
    output logic        pwm_out,
    output logic        period_start,
    output logic [11:0] duty_active,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RAMP, RUN, STOP} state_t;

    localparam int          SLEW_SAT = (SLEW_STEP > 4095) ? 4095 : SLEW_STEP;
    localparam logic [11:0] PERIOD12 = 12'(PERIOD);
    localparam logic [12:0] PERIOD13 = 13'(PERIOD);
    localparam logic [12:0] SLEW13   = 13'(SLEW_SAT);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] duty_q, duty_d;
    logic [11:0] target_q, target_d;
    logic [11:0] pend_q, pend_d;
    logic        pend_full_q, pend_full_d;
    logic        pwm_out_q, pwm_out_d;
    logic        period_start_q, period_start_d;

    logic        running;
    logic        boundary;
    logic        accept;
    logic [11:0] tgt_eff;
    logic [12:0] goal13;
    logic [12:0] duty13;
    logic [12:0] stepped;
    logic [11:0] duty_step;

    assign running  = (state_q != IDLE);
    assign boundary = running && (cnt_q == PERIOD12);
    assign accept   = pw_valid && !pend_full_q;
    assign tgt_eff  = pend_full_q ? pend_q : target_q;
    assign goal13   = (state_q == STOP) ? 13'd0 : {1'b0, tgt_eff};
    assign duty13   = {1'b0, duty_q};

    // 13-bit stepping so duty + SLEW_STEP never wraps before the goal clamp.
    assign stepped = (goal13 > duty13)
                   ? (((duty13 + SLEW13) > goal13) ? goal13 : (duty13 + SLEW13))
                   : (((duty13 - goal13) > SLEW13) ? (duty13 - SLEW13) : goal13);
    assign duty_step = (stepped > PERIOD13) ? PERIOD12 : stepped[11:0];

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (boundary) begin
            target_d    = tgt_eff;
            pend_full_d = 1'b0;
            duty_d      = duty_step;
        end
        // A command accepted on a boundary edge waits for the following boundary.
        if (accept) begin
            pend_d      = (pw_in > PERIOD12) ? PERIOD12 : pw_in;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: if (enable) state_d = RAMP;
            RAMP: begin
                if (!enable)                                 state_d = STOP;
                else if (boundary && (duty_step == tgt_eff)) state_d = RUN;
            end
            RUN: begin
                if (!enable)                              state_d = STOP;
                else if (boundary && (tgt_eff != duty_q)) state_d = RAMP;
            end
            STOP: begin
                if (enable)                                  state_d = RAMP;
                else if (boundary && (duty_step == 12'd0))   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d          = (!running || (cnt_q == PERIOD12)) ? 12'd0 : (cnt_q + 12'd1);
        pwm_out_d      = (state_d != IDLE) && (cnt_d < duty_d);
        period_start_d = (state_d != IDLE) && (cnt_d == 12'd0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 12'd0;
            duty_q         <= 12'd0;
            target_q       <= 12'd0;
            pend_q         <= 12'd0;
            pend_full_q    <= 1'b0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            target_q       <= target_d;
            pend_q         <= pend_d;
            pend_full_q    <= pend_full_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign pw_ready     = !pend_full_q;
    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign duty_active  = duty_q;
    assign busy         = (state_q == RAMP) || (state_q == STOP);

endmodule
